register_file_param: RTL
========================

Name: register_file_param

Overview:
- Parametrised successor to the core's register bank: configurable data width, address width (depth) and number of combinational read ports.
- Adds optional hardwired-zero register 0, optional write-to-read bypass, and a multi-cycle soft-clear sweep with a busy/done handshake.
- Sits in the decode stage of the KGP miniRISC datapath; read ports feed the ALU operand muxes, the write port is driven from writeback.

Parameters:
- DATA_W, 32, width of each register in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_READ, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary storage
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value only

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- rd_addr  input  NUM_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NUM_READ*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- we  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- clr_req  input  1  request a soft clear of the whole file (sampled in IDLE only)
- busy  output  1  high while the clear sweep runs
- clr_done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset: one clock with rst=0 zeroes all DEPTH entries in that edge. It also sets FSM=IDLE, sweep index=0, busy=0 and clr_done=0. Reset overrides every other input, including during a sweep.
- Writes: on a clk edge with rst=1, state IDLE and we=1, entry[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is discarded.
- Reads: combinational, zero latency. Per port k:
  - ZERO_REG=1 and rd_addr_k=0 -> 0.
  - Otherwise, if BYPASS=1, state IDLE, we=1 and wr_addr=rd_addr_k -> wr_data.
  - Otherwise -> entry[rd_addr_k].
- Read port independence: all read ports are independent; any ports may read the same address.
- FSM states and transitions:
  - IDLE: busy=0. clr_req=1 -> CLEAR with index=0. A write presented in the same cycle as clr_req is still performed, then cleared by the sweep.
  - CLEAR: busy=1. Each cycle, entry[index] <= 0 and index increments. When index=DEPTH-1 is written, go to DONE. Sweep length is exactly DEPTH cycles.
  - DONE: busy=0, clr_done=1 for exactly one cycle. Next state IDLE unconditionally; clr_req in DONE is ignored.
- While busy:
  - we is ignored (write dropped, no bypass).
  - clr_req is ignored.
  - All rd_data ports return 0, since the file is logically cleared from the first sweep cycle.
- Timing: clr_req high on edge N -> busy high from N+1 through N+DEPTH -> clr_done high in cycle N+DEPTH+1 -> IDLE at N+DEPTH+2. A write accepted at N+DEPTH+1 (DONE) is dropped; writes resume in IDLE.
- Storage: entries are unsigned bit vectors. There is no sign or width conversion; wr_data is stored verbatim.
- Out-of-range addresses are impossible by construction (DEPTH = 2**ADDR_W).

Test Plan:
- Reset/basic RW: rst=0 for 1 cycle. Write 0xDEADBEEF to r5 and 0x12345678 to r31. Read r5 on port 0 and r31 on port 1 -> 0xDEADBEEF / 0x12345678; unwritten r7 -> 0.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 -> reads of r0 return 0. ZERO_REG=0 build: same write -> r0 reads 0xFFFFFFFF.
- Bypass: r3 holds 0x11. Same cycle: we=1, wr_addr=3, wr_data=0x22, rd_addr0=3 -> rd_data0=0x22 combinationally (BYPASS=1) or 0x11 (BYPASS=0); next cycle both builds read 0x22.
- Clear sweep: fill all 32 regs with index+1, pulse clr_req at edge N. Check:
  - busy high for exactly 32 cycles.
  - clr_done pulses once at N+33.
  - writes attempted during busy are dropped.
  - All reads are 0 during and after the sweep.
- Simultaneous write+clear / clear during DONE: in IDLE, assert we (r9=0xAA) and clr_req together -> r9 reads 0 after the sweep. Assert clr_req during DONE -> no second sweep (busy stays 0).
- Reset mid-sweep: start a clear, assert rst=0 at sweep cycle 10 -> next cycle busy=0, clr_done=0, all regs 0. A write to r4=0x55 one cycle after rst=1 succeeds.
- Parametric: DATA_W=16, ADDR_W=3, NUM_READ=3 -> sweep lasts 8 cycles. Three ports reading r1, r2, r1 after writes 0xA1, 0xB2 -> 0xA1, 0xB2, 0xA1.

Source files
------------

// File: rtl/register_file_param.sv
// Parametrised register file: combinational read ports, one write port, optional
// hardwired-zero r0, optional write-to-read bypass and a DEPTH-cycle soft-clear sweep.
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         clr_req,
  output logic                         busy,
  output logic                         clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: clr_req is only looked at in IDLE; busy is high for exactly DEPTH
  // cycles of sweep, then clr_done is high for one cycle before returning to IDLE.
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_ok;

  assign wr_ok = (state_q == IDLE) && we && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (idx_q == '1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        mem[idx_q] <= '0;
        idx_q      <= idx_q + ADDR_W'(1);
      end else begin
        idx_q <= '0;
      end
      // wr_ok implies IDLE, so it never collides with the sweep write above
      if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem[ra];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat = '0;
      end else if (state_q == CLEAR) begin
        // the file is logically empty from the first sweep cycle
        rdat = '0;
      end else if ((BYPASS != 0) && (state_q == IDLE) && we && (wr_addr == ra)) begin
        rdat = wr_data;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
  end

endmodule
